lock_sequencer: RTL and testbench
=================================

// Module: lock_sequencer
// PURPOSE
//  Controller for the push-button combination lock. Consumes one-cycle debounced button pulses
//  and compares full entries against a programmable stored code. Counts failed attempts and
//  enforces a timed lockout; supports re-programming the code while unlocked. Sits between the
//  four pushButtonDet instances and the 7-seg/LED status logic, in the divided-clock domain.
// PARAMETERS
//  CODE_LEN      4             digits per entry (2..8)
//  MAX_FAIL      3             consecutive failed entries that trigger lockout (1..15)
//  LOCK_TICKS    10            tick pulses spent in LOCKOUT (1..255)
//  DEFAULT_CODE  8'b10_00_01_11 reset code, 2 bits/digit, digit0 in [1:0] (= buttons 3,1,0,2)
// PORTS
//  clk        in   1            divided system clock; all logic on posedge
//  rst        in   1            asynchronous, active-high reset
//  btn        in   4            debounced button pulses, 1 cycle wide; one-hot = digit 0..3
//  tick       in   1            1-cycle timebase pulse for lockout timer
//  relock     in   1            pulse: return to LOCKED from UNLOCKED/PROGRAM
//  prog_req   in   1            pulse: enter PROGRAM (honoured only in UNLOCKED)
//  unlocked   out  1            high in UNLOCKED and PROGRAM
//  lockout    out  1            high in LOCKOUT
//  prog_mode  out  1            high in PROGRAM
//  digit_cnt  out  4            digits accepted in current entry/program sequence
//  fail_cnt   out  4            consecutive failed entries
//  ok_pulse   out  1            1-cycle: correct entry accepted
//  bad_pulse  out  1            1-cycle: wrong entry rejected
// BEHAVIOUR
//  - Reset: state=LOCKED, code=DEFAULT_CODE, digit_cnt=0, fail_cnt=0, timer=0, all outputs 0.
//  - Press = any btn!=0. One-hot press = valid digit; multi-hot press = invalid digit.
//  - LOCKED: each press increments digit_cnt, ORs a sticky mismatch flag (invalid or !=code digit).
//    No early abort: always CODE_LEN presses. On the edge sampling the CODE_LEN-th press,
//    final match (flag|this digit) decides; outputs registered, visible next cycle (latency 1):
//      match    -> UNLOCKED, fail_cnt=0, ok_pulse=1, digit_cnt=0.
//      mismatch -> fail_cnt+1, bad_pulse=1, digit_cnt=0, flag cleared; if new fail_cnt==MAX_FAIL
//                  -> LOCKOUT with timer=LOCK_TICKS, else stay LOCKED.
//  - LOCKOUT: btn ignored; each tick decrements timer; on tick with timer==1 -> LOCKED, fail_cnt=0.
//  - UNLOCKED: btn ignored; relock -> LOCKED; prog_req -> PROGRAM, digit_cnt=0.
//    relock and prog_req in same cycle: relock wins.
//  - PROGRAM: valid press written to shadow[digit_cnt], digit_cnt+1; on CODE_LEN-th valid press
//    shadow+digit commits to code on that edge, -> UNLOCKED, ok_pulse=1. Invalid press aborts:
//    shadow discarded, code unchanged, -> UNLOCKED, bad_pulse=1. relock aborts -> LOCKED, no commit.
//  - relock/prog_req/tick ignored in states not listed above. fail_cnt saturates, never wraps.
//  - Press coincident with relock in PROGRAM: relock wins, press dropped.
//  - Reset mid-entry/mid-program/mid-lockout: immediate return to reset values incl. DEFAULT_CODE.
// STRUCTURE
//  - lock_defs.vh (shared include): state encodings S_LOCKED/S_UNLOCKED/S_PROGRAM/S_LOCKOUT (2b),
//    DIGIT_W=2, one-hot->digit encode function, valid-press (one-hot) check.
//  - Sub-module lockout_timer: load/tick-decrement down-counter with done pulse; rest is one FSM.
// TESTING
//  1 Reset, presses 1000,0010,0001,0100 -> ok_pulse 1 cycle after 4th, unlocked=1, fail_cnt=0.
//  2 Entry 1000,0010,0100,0001 -> bad_pulse, fail_cnt=1, unlocked=0; 2nd press 0011 in entry
//    counts as wrong digit -> fail on 4th press only.
//  3 Three bad entries -> lockout=1, btn ignored; 10 ticks -> lockout=0 after 10th, fail_cnt=0;
//    9 ticks + correct entry -> still locked out.
//  4 Unlock, prog_req, presses 0001x4 -> code=0; relock; 0001x4 unlocks; old code rejected.
//  5 PROGRAM with 2nd press 0110 -> abort, bad_pulse, old code still valid; relock+prog_req same
//    cycle -> LOCKED.
//  6 Assert rst mid-LOCKOUT and mid-PROGRAM -> all outputs 0, DEFAULT_CODE unlocks next.

Source files
------------

// File: rtl/lock_sequencer_pkg.sv
// Shared definitions for the combination-lock controller: state encodings,
// digit width and helpers that turn a one-hot button pulse into a digit.
package lock_sequencer_pkg;

  localparam int DIGIT_W = 2;

  typedef enum logic [1:0] {
    S_LOCKED   = 2'd0,
    S_UNLOCKED = 2'd1,
    S_PROGRAM  = 2'd2,
    S_LOCKOUT  = 2'd3
  } lock_state_t;

  // Button n maps to digit n; anything that is not one-hot yields digit 0 and
  // must be screened with isValidPress before the digit is trusted.
  function automatic logic [DIGIT_W-1:0] encodeDigit(input logic [3:0] b);
    logic [DIGIT_W-1:0] d;
    case (b)
      4'b0010: d = 2'd1;
      4'b0100: d = 2'd2;
      4'b1000: d = 2'd3;
      default: d = 2'd0;
    endcase
    return d;
  endfunction

  function automatic logic isValidPress(input logic [3:0] b);
    return (b != 4'd0) && ((b & (b - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/lock_sequencer_timer.sv
// Lockout down-counter: load sets the remaining tick count, each tick
// decrements it, and done fires on the tick that consumes the last count.
module lockout_timer
  import lock_sequencer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_loadVal,
  input  logic             i_tick,
  output logic             o_done
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_loadVal;
    end else if (i_tick && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_done = i_tick && (r_count == WIDTH'(1));

endmodule

// File: rtl/lock_sequencer.sv
// Push-button combination lock controller: checks full entries against a
// programmable code, counts failures, enforces a timed lockout, reprograms.
module lock_sequencer
  import lock_sequencer_pkg::*;
#(
  parameter int                    CODE_LEN     = 4,
  parameter int                    MAX_FAIL     = 3,
  parameter int                    LOCK_TICKS   = 10,
  parameter logic [2*CODE_LEN-1:0] DEFAULT_CODE = 8'b10_00_01_11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  input  logic       tick,
  input  logic       relock,
  input  logic       prog_req,
  output logic       unlocked,
  output logic       lockout,
  output logic       prog_mode,
  output logic [3:0] digit_cnt,
  output logic [3:0] fail_cnt,
  output logic       ok_pulse,
  output logic       bad_pulse
);

  localparam int         CODE_W     = DIGIT_W * CODE_LEN;
  localparam int         SLOT_W     = $clog2(CODE_W);
  localparam logic [3:0] LAST_IDX   = 4'(CODE_LEN - 1);
  localparam logic [3:0] FAIL_LIMIT = 4'(MAX_FAIL);
  localparam logic [7:0] TICK_LOAD  = 8'(LOCK_TICKS);

  lock_state_t         r_state;
  logic [CODE_W-1:0]   r_code;
  logic [CODE_W-1:0]   r_shadow;
  logic [3:0]          r_digitCnt;
  logic [3:0]          r_failCnt;
  logic                r_mismatch;
  logic                r_ok;
  logic                r_bad;

  lock_state_t         w_stateNext;
  logic [CODE_W-1:0]   w_codeNext;
  logic [CODE_W-1:0]   w_shadowNext;
  logic [CODE_W-1:0]   w_shadowIns;
  logic [3:0]          w_digitCntNext;
  logic [3:0]          w_failCntNext;
  logic [3:0]          w_failInc;
  logic                w_mismatchNext;
  logic                w_okNext;
  logic                w_badNext;
  logic                w_press;
  logic                w_valid;
  logic [DIGIT_W-1:0]  w_digit;
  logic [SLOT_W-1:0]   w_slot;
  logic                w_lastDigit;
  logic                w_digitMiss;
  logic                w_timerLoad;
  logic                w_timerDone;

  assign w_press     = |btn;
  assign w_valid     = isValidPress(btn);
  assign w_digit     = encodeDigit(btn);
  assign w_slot      = SLOT_W'({r_digitCnt, 1'b0});
  assign w_lastDigit = (r_digitCnt == LAST_IDX);
  assign w_digitMiss = !w_valid || (w_digit != r_code[w_slot +: DIGIT_W]);
  assign w_failInc   = (r_failCnt == 4'hF) ? r_failCnt : r_failCnt + 4'd1;

  always_comb begin
    w_shadowIns = r_shadow;
    w_shadowIns[w_slot +: DIGIT_W] = w_digit;
  end

  lockout_timer #(
    .WIDTH(8)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_timerLoad),
    .i_loadVal(TICK_LOAD),
    .i_tick   (tick && (r_state == S_LOCKOUT)),
    .o_done   (w_timerDone)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_LOCKED;
      r_code     <= DEFAULT_CODE;
      r_shadow   <= '0;
      r_digitCnt <= 4'd0;
      r_failCnt  <= 4'd0;
      r_mismatch <= 1'b0;
      r_ok       <= 1'b0;
      r_bad      <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_code     <= w_codeNext;
      r_shadow   <= w_shadowNext;
      r_digitCnt <= w_digitCntNext;
      r_failCnt  <= w_failCntNext;
      r_mismatch <= w_mismatchNext;
      r_ok       <= w_okNext;
      r_bad      <= w_badNext;
    end
  end

  // Entries always run to CODE_LEN presses so timing never reveals which digit was wrong.
  always_comb begin
    w_stateNext    = r_state;
    w_codeNext     = r_code;
    w_shadowNext   = r_shadow;
    w_digitCntNext = r_digitCnt;
    w_failCntNext  = r_failCnt;
    w_mismatchNext = r_mismatch;
    w_okNext       = 1'b0;
    w_badNext      = 1'b0;
    w_timerLoad    = 1'b0;

    case (r_state)
      S_LOCKED: begin
        if (w_press) begin
          if (w_lastDigit) begin
            w_digitCntNext = 4'd0;
            w_mismatchNext = 1'b0;
            if (!(r_mismatch || w_digitMiss)) begin
              w_stateNext   = S_UNLOCKED;
              w_failCntNext = 4'd0;
              w_okNext      = 1'b1;
            end else begin
              w_failCntNext = w_failInc;
              w_badNext     = 1'b1;
              if (w_failInc == FAIL_LIMIT) begin
                w_stateNext = S_LOCKOUT;
                w_timerLoad = 1'b1;
              end
            end
          end else begin
            w_digitCntNext = r_digitCnt + 4'd1;
            w_mismatchNext = r_mismatch || w_digitMiss;
          end
        end
      end

      S_LOCKOUT: begin
        if (w_timerDone) begin
          w_stateNext   = S_LOCKED;
          w_failCntNext = 4'd0;
        end
      end

      S_UNLOCKED: begin
        if (relock) begin
          w_stateNext = S_LOCKED;
        end else if (prog_req) begin
          w_stateNext    = S_PROGRAM;
          w_digitCntNext = 4'd0;
          w_shadowNext   = '0;
        end
      end

      S_PROGRAM: begin
        if (relock) begin
          w_stateNext    = S_LOCKED;
          w_digitCntNext = 4'd0;
        end else if (w_press) begin
          if (!w_valid) begin
            w_stateNext    = S_UNLOCKED;
            w_badNext      = 1'b1;
            w_digitCntNext = 4'd0;
          end else if (w_lastDigit) begin
            w_codeNext     = w_shadowIns;
            w_stateNext    = S_UNLOCKED;
            w_okNext       = 1'b1;
            w_digitCntNext = 4'd0;
          end else begin
            w_shadowNext   = w_shadowIns;
            w_digitCntNext = r_digitCnt + 4'd1;
          end
        end
      end

      default: begin
        w_stateNext = S_LOCKED;
      end
    endcase
  end

  assign unlocked  = (r_state == S_UNLOCKED) || (r_state == S_PROGRAM);
  assign lockout   = (r_state == S_LOCKOUT);
  assign prog_mode = (r_state == S_PROGRAM);
  assign digit_cnt = r_digitCnt;
  assign fail_cnt  = r_failCnt;
  assign ok_pulse  = r_ok;
  assign bad_pulse = r_bad;

endmodule

// File: tb/tb_lock_sequencer.sv
// Directed self-checking bench for lock_sequencer: expected output vectors are
// queued as each stimulus is driven and popped when the registered result appears.
module tb_lock_sequencer;

  logic       clk;
  logic       rst;
  logic [3:0] btn;
  logic       tick;
  logic       relock;
  logic       prog_req;
  logic       unlocked;
  logic       lockout;
  logic       prog_mode;
  logic [3:0] digit_cnt;
  logic [3:0] fail_cnt;
  logic       ok_pulse;
  logic       bad_pulse;

  typedef struct {
    string       tag;
    logic [12:0] expVal;
  } sbEntry_t;

  sbEntry_t sbQueue[$];
  int checks = 0;
  int errors = 0;

  localparam logic [15:0] DEF_SEQ   = 16'b1000_0010_0001_0100;
  localparam logic [15:0] WRONG_SEQ = 16'b1000_0010_0100_0001;
  localparam logic [15:0] MULTI_SEQ = 16'b1000_0011_0001_0100;
  localparam logic [15:0] ZERO_SEQ  = 16'b0001_0001_0001_0001;
  localparam logic [15:0] THREE_SEQ = 16'b1000_1000_1000_1000;

  lock_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .btn      (btn),
    .tick     (tick),
    .relock   (relock),
    .prog_req (prog_req),
    .unlocked (unlocked),
    .lockout  (lockout),
    .prog_mode(prog_mode),
    .digit_cnt(digit_cnt),
    .fail_cnt (fail_cnt),
    .ok_pulse (ok_pulse),
    .bad_pulse(bad_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Field order of every expected/observed vector: ok,bad,unlocked,lockout,prog,digit_cnt,fail_cnt
  function automatic logic [12:0] mkExp(input int ok, input int bad, input int unl,
                                        input int lko, input int prg, input int dc, input int fc);
    return {1'(ok), 1'(bad), 1'(unl), 1'(lko), 1'(prg), 4'(dc), 4'(fc)};
  endfunction

  function automatic logic [12:0] observed();
    return {ok_pulse, bad_pulse, unlocked, lockout, prog_mode, digit_cnt, fail_cnt};
  endfunction

  task automatic checkOutput();
    sbEntry_t    e;
    logic [12:0] got;
    checks++;
    if (sbQueue.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_underflow: observed empty queue, required one entry");
    end else begin
      e   = sbQueue.pop_front();
      got = observed();
      assert (got === e.expVal) else begin
        errors++;
        $error("[TB] FAIL %s: observed ok,bad,unl,lko,prg,dc,fc=%b required %b",
               e.tag, got, e.expVal);
      end
    end
  endtask

  task automatic applyStimulus(input string tag, input logic [3:0] b, input int t,
                               input int r, input int p, input logic [12:0] e);
    sbQueue.push_back('{tag: tag, expVal: e});
    btn      = b;
    tick     = 1'(t);
    relock   = 1'(r);
    prog_req = 1'(p);
    @(negedge clk);
    btn      = 4'd0;
    tick     = 1'b0;
    relock   = 1'b0;
    prog_req = 1'b0;
    checkOutput();
  endtask

  // Four presses, first press in seq[15:12]; the first three only advance digit_cnt.
  task automatic enterCode(input string tag, input logic [15:0] seq, input int unl,
                           input int prg, input int fc, input logic [12:0] finalExp);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(tag, seq[15-4*i -: 4], 0, 0, 0, mkExp(0, 0, unl, 0, prg, i + 1, fc));
    end
    applyStimulus(tag, seq[3:0], 0, 0, 0, finalExp);
  endtask

  task automatic lockedOutPresses(input string tag, input logic [15:0] seq, input int fc);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(tag, seq[15-4*i -: 4], 0, 0, 0, mkExp(0, 0, 0, 1, 0, 0, fc));
    end
  endtask

  // Reset is raised mid-cycle to show it clears state without waiting for a clock edge.
  task automatic resetPulse(input string tag);
    sbQueue.push_back('{tag: tag, expVal: mkExp(0, 0, 0, 0, 0, 0, 0)});
    #2 rst = 1'b1;
    #1 checkOutput();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    btn      = 4'd0;
    tick     = 1'b0;
    relock   = 1'b0;
    prog_req = 1'b0;
    #1;
    sbQueue.push_back('{tag: "reset_state", expVal: mkExp(0, 0, 0, 0, 0, 0, 0)});
    checkOutput();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    $display("[TB] default code unlock");
    enterCode("t1_default", DEF_SEQ, 0, 0, 0, mkExp(1, 0, 1, 0, 0, 0, 0));
    applyStimulus("t1_ok_one_cycle", 4'b0000, 0, 0, 0, mkExp(0, 0, 1, 0, 0, 0, 0));
    applyStimulus("t1_btn_ignored", 4'b1000, 0, 0, 0, mkExp(0, 0, 1, 0, 0, 0, 0));
    applyStimulus("t1_relock", 4'b0000, 0, 1, 0, mkExp(0, 0, 0, 0, 0, 0, 0));

    $display("[TB] wrong entries");
    enterCode("t2_wrong", WRONG_SEQ, 0, 0, 0, mkExp(0, 1, 0, 0, 0, 0, 1));
    enterCode("t2_multihot", MULTI_SEQ, 0, 0, 1, mkExp(0, 1, 0, 0, 0, 0, 2));

    $display("[TB] lockout");
    enterCode("t3_third_bad", ZERO_SEQ, 0, 0, 2, mkExp(0, 1, 0, 1, 0, 0, 3));
    applyStimulus("t3_btn_ignored", 4'b1000, 0, 0, 0, mkExp(0, 0, 0, 1, 0, 0, 3));
    applyStimulus("t3_relock_ignored", 4'b0000, 0, 1, 1, mkExp(0, 0, 0, 1, 0, 0, 3));
    for (int i = 0; i < 9; i++) begin
      applyStimulus("t3_tick", 4'b0000, 1, 0, 0, mkExp(0, 0, 0, 1, 0, 0, 3));
    end
    lockedOutPresses("t3_entry_in_lockout", DEF_SEQ, 3);
    applyStimulus("t3_tick10", 4'b0000, 1, 0, 0, mkExp(0, 0, 0, 0, 0, 0, 0));

    $display("[TB] reprogram");
    enterCode("t4_unlock", DEF_SEQ, 0, 0, 0, mkExp(1, 0, 1, 0, 0, 0, 0));
    applyStimulus("t4_prog_req", 4'b0000, 0, 0, 1, mkExp(0, 0, 1, 0, 1, 0, 0));
    enterCode("t4_program", ZERO_SEQ, 1, 1, 0, mkExp(1, 0, 1, 0, 0, 0, 0));
    applyStimulus("t4_relock", 4'b0000, 0, 1, 0, mkExp(0, 0, 0, 0, 0, 0, 0));
    enterCode("t4_new_code", ZERO_SEQ, 0, 0, 0, mkExp(1, 0, 1, 0, 0, 0, 0));
    applyStimulus("t4_relock2", 4'b0000, 0, 1, 0, mkExp(0, 0, 0, 0, 0, 0, 0));
    enterCode("t4_old_rejected", DEF_SEQ, 0, 0, 0, mkExp(0, 1, 0, 0, 0, 0, 1));

    $display("[TB] program aborts");
    enterCode("t5_unlock", ZERO_SEQ, 0, 0, 1, mkExp(1, 0, 1, 0, 0, 0, 0));
    applyStimulus("t5_prog_req", 4'b0000, 0, 0, 1, mkExp(0, 0, 1, 0, 1, 0, 0));
    applyStimulus("t5_prog_d0", 4'b0010, 0, 0, 0, mkExp(0, 0, 1, 0, 1, 1, 0));
    applyStimulus("t5_prog_invalid", 4'b0110, 0, 0, 0, mkExp(0, 1, 1, 0, 0, 0, 0));
    applyStimulus("t5_relock", 4'b0000, 0, 1, 0, mkExp(0, 0, 0, 0, 0, 0, 0));
    enterCode("t5_code_kept", ZERO_SEQ, 0, 0, 0, mkExp(1, 0, 1, 0, 0, 0, 0));
    applyStimulus("t5_relock_beats_prog", 4'b0000, 0, 1, 1, mkExp(0, 0, 0, 0, 0, 0, 0));
    enterCode("t5_unlock2", ZERO_SEQ, 0, 0, 0, mkExp(1, 0, 1, 0, 0, 0, 0));
    applyStimulus("t5_prog_req2", 4'b0000, 0, 0, 1, mkExp(0, 0, 1, 0, 1, 0, 0));
    applyStimulus("t5_prog_d0b", 4'b1000, 0, 0, 0, mkExp(0, 0, 1, 0, 1, 1, 0));
    applyStimulus("t5_relock_drops_press", 4'b0100, 0, 1, 0, mkExp(0, 0, 0, 0, 0, 0, 0));
    enterCode("t5_no_commit", ZERO_SEQ, 0, 0, 0, mkExp(1, 0, 1, 0, 0, 0, 0));
    applyStimulus("t5_relock2", 4'b0000, 0, 1, 0, mkExp(0, 0, 0, 0, 0, 0, 0));

    $display("[TB] reset mid-lockout and mid-program");
    enterCode("t6_bad1", THREE_SEQ, 0, 0, 0, mkExp(0, 1, 0, 0, 0, 0, 1));
    enterCode("t6_bad2", THREE_SEQ, 0, 0, 1, mkExp(0, 1, 0, 0, 0, 0, 2));
    enterCode("t6_bad3", THREE_SEQ, 0, 0, 2, mkExp(0, 1, 0, 1, 0, 0, 3));
    applyStimulus("t6_tick", 4'b0000, 1, 0, 0, mkExp(0, 0, 0, 1, 0, 0, 3));
    applyStimulus("t6_tick", 4'b0000, 1, 0, 0, mkExp(0, 0, 0, 1, 0, 0, 3));
    resetPulse("t6_rst_lockout");
    enterCode("t6_default_after_lockout", DEF_SEQ, 0, 0, 0, mkExp(1, 0, 1, 0, 0, 0, 0));
    applyStimulus("t6_prog_req", 4'b0000, 0, 0, 1, mkExp(0, 0, 1, 0, 1, 0, 0));
    applyStimulus("t6_prog_d0", 4'b0001, 0, 0, 0, mkExp(0, 0, 1, 0, 1, 1, 0));
    applyStimulus("t6_prog_d1", 4'b0001, 0, 0, 0, mkExp(0, 0, 1, 0, 1, 2, 0));
    resetPulse("t6_rst_program");
    enterCode("t6_default_after_program", DEF_SEQ, 0, 0, 0, mkExp(1, 0, 1, 0, 0, 0, 0));

    checks++;
    assert (sbQueue.size() === 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard_drain: observed %0d pending entries, required 0", sbQueue.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
